// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   state_e     : sequencer FSM states
//   INSTR_BYTES : bytes per instruction word (sequential PC step)
//   ALIGN_MASK  : low address bits that must be zero for a legal PC
//   is_aligned  : true when the given low address bits are word aligned
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt,
    StFault
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus.
//   req   : request, held high while the sequencer is fetching
//   addr  : request address
//   ack   : read data valid this cycle
//   rdata : instruction word
// master = sequencer side, slave = memory side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the EXEC state.
//   pc_i            : current program counter
//   halt_i, jump_i, branch_i, zero_i : decoder/ALU control
//   jump_target_i, branch_target_i   : redirect addresses
//   next_pc_o       : PC to load on retirement (PC itself on halt or fault)
//   halt_o          : halt selected
//   misalign_o      : selected redirect target is misaligned
//   fault_addr_o    : selected redirect target (valid when misalign_o)
module fetch_next_pc
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              halt_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              halt_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] fault_addr_o
);

  logic              redirect;
  logic [ADDR_W-1:0] target;

  // Priority: halt > jump > taken branch > sequential.
  always_comb begin
    halt_o   = 1'b0;
    redirect = 1'b0;
    target   = '0;
    if (halt_i) begin
      halt_o = 1'b1;
    end else if (jump_i) begin
      redirect = 1'b1;
      target   = jump_target_i;
    end else if (branch_i && zero_i) begin
      redirect = 1'b1;
      target   = branch_target_i;
    end
  end

  always_comb begin
    misalign_o   = redirect && !is_aligned(target[1:0]);
    fault_addr_o = target;
    if (halt_o || misalign_o) begin
      next_pc_o = pc_i;
    end else if (redirect) begin
      next_pc_o = target;
    end else begin
      // Natural wrap modulo 2^ADDR_W.
      next_pc_o = pc_i + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: launches at start_pc, fetches a word over the
// imem bus, holds it for one (or more, when stalled) EXEC cycles, then picks
// the next PC, halts, or faults on a misaligned target.
//   clk, rst      : clock, asynchronous active-high reset
//   start/start_pc: launch request honoured in IDLE/HALT/FAULT
//   imem          : instruction-memory bus (master side)
//   instr/instr_valid : captured word and its execute strobe
//   stall         : holds EXEC
//   halt/jump/branch/zero, jump_target/branch_target : next-PC control
//   PC, halted, fault, fault_addr, retired : status
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_pc,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                halt,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero,
  input  logic [ADDR_W-1:0]   jump_target,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [ADDR_W-1:0]   PC,
  output logic                halted,
  output logic                fault,
  output logic [ADDR_W-1:0]   fault_addr,
  output logic [31:0]         retired
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              halted_q, fault_q;
  logic [ADDR_W-1:0] fault_addr_q;
  logic [31:0]       retired_q;

  logic [ADDR_W-1:0] next_pc;
  logic              sel_halt, sel_misalign;
  logic [ADDR_W-1:0] sel_fault_addr;
  logic              can_start, start_ok, retire;

  fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i            (pc_q),
    .halt_i          (halt),
    .jump_i          (jump),
    .branch_i        (branch),
    .zero_i          (zero),
    .jump_target_i   (jump_target),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc),
    .halt_o          (sel_halt),
    .misalign_o      (sel_misalign),
    .fault_addr_o    (sel_fault_addr)
  );

  assign can_start = (state_q == StIdle) || (state_q == StHalt) || (state_q == StFault);
  assign start_ok  = is_aligned(start_pc[1:0]);
  assign retire    = (state_q == StExec) && !stall;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalt, StFault: begin
        if (start) begin
          state_d = start_ok ? StFetch : StFault;
        end
      end
      StFetch: begin
        if (imem.ack) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (!stall) begin
          if (sel_halt) begin
            state_d = StHalt;
          end else if (sel_misalign) begin
            state_d = StFault;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs.
  always_comb begin
    imem.req    = (state_q == StFetch);
    instr_valid = (state_q == StExec);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      retired_q    <= '0;
    end else begin
      if (can_start && start) begin
        if (start_ok) begin
          pc_q     <= start_pc;
          halted_q <= 1'b0;
          fault_q  <= 1'b0;
        end else begin
          fault_q      <= 1'b1;
          fault_addr_q <= start_pc;
        end
      end
      if ((state_q == StFetch) && imem.ack) begin
        instr_q <= imem.rdata;
      end
      if (retire) begin
        retired_q <= retired_q + 32'd1;
        pc_q      <= next_pc;
        if (sel_halt) begin
          halted_q <= 1'b1;
        end else if (sel_misalign) begin
          fault_q      <= 1'b1;
          fault_addr_q <= sel_fault_addr;
        end
      end
    end
  end

  assign imem.addr  = pc_q;
  assign PC         = pc_q;
  assign instr      = instr_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign retired    = retired_q;

endmodule
